timer_peripheral: RTL and testbench

Memory-mapped peripheral block on the data-memory bus of the pipelined MIPS processor. It provides a reloadable 32-bit timer that generates the `IRQ` level consumed by the instruction decoder, LED, switch and 7-segment display registers, and a free-running system tick counter. The CPU reaches it through `lw`/`sw` to the 0x4000_00xx window. It is the interrupt source at the far end of the decoder's `IRQ` input.

---
 rtl/timer_peripheral_if.sv | 10 +
 rtl/timer_peripheral.sv | 69 ++++++
 tb/tb_timer_peripheral.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/timer_peripheral_if.sv
// timer_peripheral_if: data-memory bus between the CPU and the timer peripheral
interface timer_peripheral_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  modport master(output MemRd, MemWr, Address, WriteData, input ReadData);
  modport slave(input MemRd, MemWr, Address, WriteData, output ReadData);
endinterface

// File: rtl/timer_peripheral.sv
// timer_peripheral: reloadable timer with IRQ, LED/switch/7-seg registers and systick
module timer_peripheral #(
  parameter logic [31:0] TH_RESET = 32'h0000_0000,
  parameter logic [31:0] TL_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  timer_peripheral_if.slave bus,
  input  logic [7:0]        switch,
  output logic [7:0]        led,
  output logic [11:0]       digi,
  output logic              IRQ
);
  logic [31:0] th_q, th_d, tl_q, tl_d, tick_q, rdata;
  logic [2:0]  tcon_q, tcon_d, idx;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic        irq_q, hit, we, ovf, set_st;
  assign idx    = bus.Address[4:2];
  assign hit    = bus.Address[31:5] == 27'h200_0000 && idx != 3'd7;
  assign we     = bus.MemWr && hit;
  assign ovf    = tcon_q[0] && &tl_q;
  assign set_st = ovf && tcon_q[1];
  always_comb begin
    th_d   = we && idx == 3'd0 ? bus.WriteData : th_q;
    tl_d   = we && idx == 3'd1 ? bus.WriteData : !tcon_q[0] ? tl_q : ovf ? th_q : tl_q + 32'd1;
    tcon_d = we && idx == 3'd2 ? {tcon_q[2] & bus.WriteData[2], bus.WriteData[1:0]} : tcon_q;
    tcon_d[2] = tcon_d[2] | set_st;
    led_d  = we && idx == 3'd3 ? bus.WriteData[7:0] : led_q;
    digi_d = we && idx == 3'd5 ? bus.WriteData[11:0] : digi_q;
  end
  always_comb begin
    rdata = 32'd0;
    if (bus.MemRd && hit)
      case (idx)
        3'd0:    rdata = th_q;
        3'd1:    rdata = tl_q;
        3'd2:    rdata = {29'd0, tcon_q};
        3'd3:    rdata = {24'd0, led_q};
        3'd4:    rdata = {24'd0, switch};
        3'd5:    rdata = {20'd0, digi_q};
        3'd6:    rdata = tick_q;
        default: rdata = 32'd0;
      endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= TH_RESET;
      tl_q   <= TL_RESET;
      tcon_q <= 3'd0;
      led_q  <= 8'd0;
      digi_q <= 12'd0;
      tick_q <= 32'd0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      tick_q <= tick_q + 32'd1;
      irq_q  <= tcon_d[1] & tcon_d[2];
    end
  end
  assign bus.ReadData = rdata;
  assign led          = led_q;
  assign digi         = digi_q;
  assign IRQ          = irq_q;
endmodule

// File: tb/tb_timer_peripheral.sv
// tb_timer_peripheral: directed and random bus traffic checked against a behavioural model
module tb_timer_peripheral;
  localparam logic [31:0] TH_R = 32'h0000_0020;
  localparam logic [31:0] TL_R = 32'h0000_0010;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 1'b0, reset;
  logic [7:0] switch, led;
  logic [11:0] digi;
  logic irq;
  int checks = 0, failures = 0;
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0] m_tcon;
  logic [7:0] m_led;
  logic [11:0] m_digi;
  logic m_irq;
  timer_peripheral_if bus();
  timer_peripheral #(.TH_RESET(TH_R), .TL_RESET(TL_R)) dut (
    .clk(clk), .reset(reset), .bus(bus), .switch(switch),
    .led(led), .digi(digi), .IRQ(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic m_reset();
    m_th = TH_R; m_tl = TL_R; m_tcon = 3'd0; m_led = 8'd0;
    m_digi = 12'd0; m_tick = 32'd0; m_irq = 1'b0;
  endtask
  function automatic int m_index(input logic [31:0] a);
    if (a < BASE || a > BASE + 32'h1B) return -1;
    return int'((a - BASE) >> 2);
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (m_index(a))
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_tcon};
      3: return {24'd0, m_led};
      4: return {24'd0, switch};
      5: return {20'd0, m_digi};
      6: return m_tick;
      default: return 32'd0;
    endcase
  endfunction
  task automatic m_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic overflow, raise;
    logic [31:0] ntl;
    logic [2:0] ntcon;
    int i;
    overflow = m_tcon[0] && m_tl == 32'hFFFF_FFFF;
    raise = overflow && m_tcon[1];
    ntl = !m_tcon[0] ? m_tl : overflow ? m_th : m_tl + 1;
    ntcon = m_tcon;
    i = wr ? m_index(a) : -1;
    if (i == 0) m_th = d;
    if (i == 1) ntl = d;
    if (i == 2) ntcon = {m_tcon[2] && d[2], d[1:0]};
    if (i == 3) m_led = d[7:0];
    if (i == 5) m_digi = d[11:0];
    if (raise) ntcon[2] = 1'b1;
    m_tl = ntl;
    m_tcon = ntcon;
    m_irq = ntcon[1] && ntcon[2];
    m_tick = m_tick + 1;
  endtask
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
    bus.MemRd = rd; bus.MemWr = wr; bus.Address = a; bus.WriteData = d;
    #2;
    check({tag, "_rdata"}, bus.ReadData, rd ? m_read(a) : 32'd0);
    m_step(wr, a, d);
    @(posedge clk);
    #1;
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    check({tag, "_led"}, {24'd0, led}, {24'd0, m_led});
    check({tag, "_digi"}, {20'd0, digi}, {20'd0, m_digi});
    bus.MemRd = 1'b0; bus.MemWr = 1'b0;
  endtask
  initial begin
    reset = 1'b1; switch = 8'h00;
    bus.MemRd = 1'b0; bus.MemWr = 1'b0; bus.Address = 32'd0; bus.WriteData = 32'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    check("reset_irq", {31'd0, irq}, 32'd0);
    cyc(1, 0, BASE + 4, 0, "reset_tl");
    cyc(1, 0, BASE + 8, 0, "reset_tcon");
    cyc(1, 0, BASE, 0, "reset_th");
    // reload and interrupt
    cyc(0, 1, BASE, 32'hFFFF_FFFC, "wr_th");
    cyc(0, 1, BASE + 4, 32'hFFFF_FFFE, "wr_tl");
    cyc(0, 1, BASE + 8, 32'd3, "wr_tcon");
    cyc(1, 0, BASE + 4, 0, "tl_a");
    cyc(1, 0, BASE + 4, 0, "tl_ovf");
    check("irq_on_reload", {31'd0, irq}, 32'd1);
    cyc(1, 0, BASE + 8, 0, "tcon_after_reload");
    cyc(0, 1, BASE + 8, 32'd3, "clear");
    check("irq_cleared", {31'd0, irq}, 32'd0);
    cyc(1, 0, BASE + 4, 0, "tl_count_on");
    cyc(0, 1, BASE + 8, 32'd3, "clear_on_ovf");
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    cyc(0, 1, BASE + 8, 32'd3, "clear2");
    // masking
    cyc(0, 1, BASE + 8, 32'd1, "mask");
    cyc(1, 0, BASE + 4, 0, "mask_tl0");
    cyc(1, 0, BASE + 4, 0, "mask_tl1");
    cyc(1, 0, BASE + 4, 0, "mask_tl2");
    check("mask_irq", {31'd0, irq}, 32'd0);
    cyc(1, 0, BASE + 8, 0, "mask_tcon");
    cyc(0, 1, BASE + 8, 32'd3, "unmask");
    check("unmask_irq", {31'd0, irq}, 32'd0);
    // TL write during overflow wins over reload
    cyc(0, 1, BASE + 4, 32'hFFFF_FFFF, "pre_ovf");
    cyc(0, 1, BASE + 4, 32'd5, "tl_wr_on_ovf");
    check("simul_irq", {31'd0, irq}, 32'd1);
    bus.MemRd = 1'b1; bus.Address = BASE + 4;
    #1 check("simul_tl", bus.ReadData, 32'd5);
    cyc(1, 0, BASE + 4, 0, "simul_tl_model");
    // peripherals
    switch = 8'hA5;
    bus.MemRd = 1'b1; bus.Address = BASE + 32'h10;
    #1 check("switch_read", bus.ReadData, 32'h0000_00A5);
    cyc(1, 0, BASE + 32'h10, 0, "switch");
    cyc(0, 1, BASE + 32'h0C, 32'h1234_5681, "led_wr");
    check("led_port", {24'd0, led}, 32'h81);
    bus.MemRd = 1'b1; bus.Address = BASE + 32'h0C;
    #1 check("led_read", bus.ReadData, 32'h81);
    cyc(0, 1, BASE + 32'h14, 32'h0000_0FFF, "digi_wr");
    check("digi_port", {20'd0, digi}, 32'hFFF);
    cyc(1, 0, BASE + 32'h20, 0, "unmapped");
    cyc(0, 1, BASE + 32'h10, 32'hFFFF_FFFF, "switch_wr_ignored");
    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      int r;
      r = $urandom_range(0, 9);
      a = r <= 7 ? BASE + 32'(r * 4) + 32'($urandom_range(0, 3)) : r == 8 ? BASE + 32'h20 : $urandom;
      d = $urandom;
      if (r == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      switch = 8'($urandom);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, a, d, "rand");
    end
    // asynchronous reset mid-count with status set
    cyc(0, 1, BASE + 8, 32'd3, "pre_rst_tcon");
    cyc(0, 1, BASE + 4, 32'hFFFF_FFFF, "pre_rst_tl");
    cyc(1, 0, BASE + 8, 0, "pre_rst_ovf");
    cyc(1, 0, BASE + 8, 0, "pre_rst_status");
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_irq_async", {31'd0, irq}, 32'd0);
    bus.MemRd = 1'b1; bus.Address = BASE + 8;
    #1 check("rst_tcon", bus.ReadData, 32'd0);
    bus.Address = BASE + 32'h18;
    #1 check("rst_tick", bus.ReadData, 32'd0);
    bus.Address = BASE + 4;
    #1 check("rst_tl", bus.ReadData, TL_R);
    bus.MemRd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    for (int n = 0; n < 4; n++) cyc(1, 0, BASE + 32'(n * 4 + 4), 0, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
